// File: rtl/mips_exec_param.sv
// Parametrised single-issue executor: decodes one R/I-type instruction, runs an ALU op or a
// multi-cycle binary GCD against an NREG x DW register file, then presents NOUT selected registers.
module mips_exec_param #(
    parameter int DW         = 16,
    parameter int NREG       = 6,
    parameter int NOUT       = 4,
    parameter int GCD_UNROLL = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instruction,
    input  logic [5*NOUT-1:0]    output_reg,
    output logic                 out_valid,
    output logic                 instruction_fail,
    output logic [DW*NOUT-1:0]   out_data,
    output logic [1:0]           dbg_state
);
    // Handshake: an instruction transfers on a rising edge where in_valid && in_ready; in_ready
    // is high only in IDLE, in_valid at any other time is dropped, and out_valid is a one-cycle
    // pulse that nothing can stall.
    localparam int KW = $clog2(DW) + 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_GCD, S_OUT} state_t;
    state_t state, state_nx;

    logic [31:0]       instr_q;
    logic [5*NOUT-1:0] oreg_q;
    logic              fail_q, fail_nx;
    logic [DW-1:0]     regs [NREG];

    logic [DW-1:0] ga, gb, ga_nx, gb_nx, st_a, st_b, st_res, diff;
    logic [KW-1:0] gk, gk_nx, st_k;
    logic          st_done;

    logic [5:0]    op;
    logic [4:0]    rs, rt, rd, dest, sel;
    logic [3:0]    shamt;
    logic [6:0]    funct;
    logic [DW-1:0] imm_ext, rs_val, rt_val, alu_res, wd;
    logic          alu_bad, is_gcd, dec_fail, gcd_multi, we;

    function automatic logic addr_ok(input logic [4:0] a);
        return {27'b0, a} < NREG;
    endfunction

    assign op      = instr_q[31:26];
    assign rs      = instr_q[25:21];
    assign rt      = instr_q[20:16];
    assign rd      = instr_q[15:11];
    assign shamt   = instr_q[10:7];
    assign funct   = instr_q[6:0];
    assign imm_ext = DW'($signed(instr_q[15:0]));
    assign dest    = (op == 6'b001000) ? rt : rd;

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rs == 5'(i)) rs_val = regs[i];
            if (rt == 5'(i)) rt_val = regs[i];
        end
    end

    always_comb begin
        alu_res = '0;
        alu_bad = 1'b0;
        is_gcd  = 1'b0;
        if (op == 6'b000000) begin
            case (funct)
                7'b0100000: alu_res = rs_val + rt_val;
                7'b0100010: alu_res = rs_val - rt_val;
                7'b0100100: alu_res = rs_val & rt_val;
                7'b0100101: alu_res = rs_val | rt_val;
                7'b0100111: alu_res = ~(rs_val | rt_val);
                7'b0101010: alu_res = DW'(rs_val < rt_val);
                7'b0000000: alu_res = rt_val << shamt;
                7'b0000010: alu_res = rt_val >> shamt;
                7'b1111000: begin
                    is_gcd  = 1'b1;
                    alu_res = rs_val; // gcd(x, x) = x, finished in the single-cycle path
                end
                default:    alu_bad = 1'b1;
            endcase
        end else if (op == 6'b001000) begin
            alu_res = rs_val + imm_ext;
        end else begin
            alu_bad = 1'b1;
        end
        dec_fail  = alu_bad || !addr_ok(rs) || !addr_ok(rt) || !addr_ok(dest) ||
                    (is_gcd && (rs_val == '0 || rt_val == '0));
        gcd_multi = is_gcd && !dec_fail && (rs != rt);
    end

    // Stein steps; a step is skipped once a == b so the unrolled chain stops at the first match.
    always_comb begin
        st_a = ga;
        st_b = gb;
        st_k = gk;
        diff = '0;
        for (int s = 0; s < GCD_UNROLL; s++) begin
            if (st_a != st_b) begin
                if (!st_a[0] && !st_b[0]) begin
                    st_a = st_a >> 1;
                    st_b = st_b >> 1;
                    st_k = st_k + KW'(1);
                end else if (!st_a[0]) begin
                    st_a = st_a >> 1;
                end else if (!st_b[0]) begin
                    st_b = st_b >> 1;
                end else begin
                    diff = (st_a > st_b) ? st_a - st_b : st_b - st_a;
                    st_b = (st_a < st_b) ? st_a : st_b;
                    st_a = diff >> 1;
                end
            end
        end
        st_done = (st_a == st_b);
        st_res  = st_a << st_k;
    end

    always_comb begin
        state_nx = state;
        fail_nx  = fail_q;
        we       = 1'b0;
        wd       = alu_res;
        ga_nx    = ga;
        gb_nx    = gb;
        gk_nx    = gk;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nx = S_EXEC;
                    fail_nx  = 1'b0;
                end
            end
            S_EXEC: begin
                fail_nx = dec_fail;
                if (gcd_multi) begin
                    ga_nx    = rs_val;
                    gb_nx    = rt_val;
                    gk_nx    = '0;
                    state_nx = S_GCD;
                end else begin
                    we       = !dec_fail;
                    state_nx = S_OUT;
                end
            end
            S_GCD: begin
                ga_nx = st_a;
                gb_nx = st_b;
                gk_nx = st_k;
                if (st_done) begin
                    we       = 1'b1;
                    wd       = st_res;
                    state_nx = S_OUT;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            fail_q  <= 1'b0;
            instr_q <= '0;
            oreg_q  <= '0;
            ga      <= '0;
            gb      <= '0;
            gk      <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state  <= state_nx;
            fail_q <= fail_nx;
            ga     <= ga_nx;
            gb     <= gb_nx;
            gk     <= gk_nx;
            if (state == S_IDLE && in_valid) begin
                instr_q <= instruction;
                oreg_q  <= output_reg;
            end
            for (int i = 0; i < NREG; i++)
                if (we && dest == 5'(i)) regs[i] <= wd;
        end
    end

    // Reads the register file after the write, so the instruction's own result is visible.
    always_comb begin
        out_data = '0;
        sel      = '0;
        for (int k = 0; k < NOUT; k++) begin
            sel = oreg_q[5*k +: 5];
            for (int i = 0; i < NREG; i++)
                if (state == S_OUT && !fail_q && sel == 5'(i))
                    out_data[DW*k +: DW] = regs[i];
        end
    end

    assign in_ready         = (state == S_IDLE);
    assign out_valid        = (state == S_OUT);
    assign instruction_fail = out_valid && fail_q;
    assign dbg_state        = state;
endmodule

// File: tb/tb_mips_exec_param.sv
// Self-checking bench for mips_exec_param: a reference model predicts each result, the
// expectation is queued at issue and popped when out_valid pulses.
module tb_mips_exec_param;
    localparam int DW   = 16;
    localparam int NREG = 6;
    localparam int NOUT = 4;
    localparam int W    = 1 + DW*NOUT;

    localparam logic [6:0] F_ADD = 7'b0100000, F_SUB = 7'b0100010, F_AND = 7'b0100100,
                           F_OR  = 7'b0100101, F_NOR = 7'b0100111, F_SLT = 7'b0101010,
                           F_SLL = 7'b0000000, F_SRL = 7'b0000010, F_GCD = 7'b1111000;

    logic                 clk, rst_n, in_valid, in_ready, out_valid, instruction_fail;
    logic [31:0]          instruction;
    logic [5*NOUT-1:0]    output_reg;
    logic [DW*NOUT-1:0]   out_data;
    logic [1:0]           dbg_state;

    mips_exec_param #(.DW(DW), .NREG(NREG), .NOUT(NOUT), .GCD_UNROLL(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .output_reg(output_reg), .out_valid(out_valid),
        .instruction_fail(instruction_fail), .out_data(out_data), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]  exp_q[$];
    int            vec_cnt = 0;
    int            miscompares = 0;
    logic [DW-1:0] m_regs [NREG];
    logic          m_fail, m_multi;

    function automatic logic [31:0] r_ins(input logic [6:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [3:0] sh);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {6'b001000, rs, rt, imm};
    endfunction

    function automatic logic [19:0] of4(input logic [4:0] f0, input logic [4:0] f1,
                                        input logic [4:0] f2, input logic [4:0] f3);
        return {f3, f2, f1, f0};
    endfunction

    function automatic logic [DW-1:0] rd_model(input logic [4:0] a);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) if (a == 5'(i)) v = m_regs[i];
        return v;
    endfunction

    task automatic model_exec(input logic [31:0] ins);
        logic [5:0]    op;
        logic [4:0]    rs, rt, rd, dest;
        logic [3:0]    sh;
        logic [6:0]    fn;
        logic [DW-1:0] a, b, r, x, y, t;
        logic          bad, gcd;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        sh = ins[10:7];  fn = ins[6:0];
        a = rd_model(rs); b = rd_model(rt);
        r = '0; bad = 1'b0; gcd = 1'b0; dest = rd;
        if (op == 6'b000000) begin
            case (fn)
                F_ADD: r = a + b;
                F_SUB: r = a - b;
                F_AND: r = a & b;
                F_OR:  r = a | b;
                F_NOR: r = ~(a | b);
                F_SLT: r = (a < b) ? 16'd1 : 16'd0;
                F_SLL: r = b << sh;
                F_SRL: r = b >> sh;
                F_GCD: begin
                    gcd = 1'b1;
                    if (a == 0 || b == 0) bad = 1'b1;
                    else begin
                        x = a; y = b;
                        while (y != 0) begin t = x % y; x = y; y = t; end
                        r = x;
                    end
                end
                default: bad = 1'b1;
            endcase
        end else if (op == 6'b001000) begin
            dest = rt;
            r = a + ins[15:0];
        end else begin
            bad = 1'b1;
        end
        if (int'(rs) >= NREG || int'(rt) >= NREG || int'(dest) >= NREG) bad = 1'b1;
        if (!bad)
            for (int i = 0; i < NREG; i++) if (dest == 5'(i)) m_regs[i] = r;
        m_fail  = bad;
        m_multi = gcd && !bad && (rs != rt);
    endtask

    task automatic build_exp(input logic [19:0] oreg, output logic [W-1:0] e);
        logic [4:0] f;
        e = '0;
        e[W-1] = m_fail;
        for (int k = 0; k < NOUT; k++) begin
            f = oreg[5*k +: 5];
            if (!m_fail && int'(f) < NREG) e[DW*k +: DW] = rd_model(f);
        end
    endtask

    // Issues one instruction at a negedge and checks its result pulse; noise pokes in_valid
    // once while the DUT is busy.
    task automatic send(input logic [31:0] ins, input logic [19:0] oreg, input bit noise);
        int           cnt, lat;
        logic [W-1:0] e, got;
        cnt = 0;
        while (!in_ready && cnt < 100) begin @(negedge clk); cnt++; end
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
            miscompares++;
        end
        in_valid = 1'b1; instruction = ins; output_reg = oreg;
        model_exec(ins);
        build_exp(oreg, e);
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; instruction = $urandom; output_reg = 20'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            vec_cnt++;
            if (in_ready !== 1'b0) begin
                $display("FAIL busy_ready: in_ready=%b required 0 at lat %0d", in_ready, lat);
                miscompares++;
            end
            if (noise && lat == 1) in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end
        vec_cnt++;
        if (out_valid !== 1'b1) begin
            $display("FAIL out_timeout: no out_valid for instr %h", ins);
            miscompares++;
            void'(exp_q.pop_front());
            return;
        end
        if (!m_multi) begin
            vec_cnt++;
            if (lat != 2) begin
                $display("FAIL latency: instr %h out_valid at T+%0d required T+2", ins, lat);
                miscompares++;
            end
        end
        got = {instruction_fail, out_data};
        e = exp_q.pop_front();
        vec_cnt++;
        if (got !== e) begin
            $display("FAIL result: instr %h got fail=%b data=%h required fail=%b data=%h",
                     ins, got[W-1], got[W-2:0], e[W-1], e[W-2:0]);
            miscompares++;
        end
        vec_cnt++;
        if (in_ready !== 1'b0) begin
            $display("FAIL out_ready: in_ready=%b during out_valid, required 0", in_ready);
            miscompares++;
        end
        @(negedge clk);
        vec_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL after_out: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
            miscompares++;
        end
    endtask

    task automatic check_idle_zero(input string name);
        vec_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || instruction_fail !== 1'b0 ||
            out_data !== '0) begin
            $display("FAIL %s: ready=%b valid=%b fail=%b data=%h required 1/0/0/0",
                     name, in_ready, out_valid, instruction_fail, out_data);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; instruction = '0; output_reg = '0;
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("reset_release");
    endtask

    task automatic test_addi();
        send(i_ins(5'd0, 5'd1, 16'h0030), of4(5'd1, 5'd0, 5'd0, 5'd0), 1'b0);
        vec_cnt++;
        if (m_regs[1] !== 16'h0030) begin
            $display("FAIL addi_model: r1=%h required 0030", m_regs[1]);
            miscompares++;
        end
    endtask

    task automatic test_gcd();
        send(i_ins(5'd0, 5'd2, 16'h0012), of4(5'd2, 5'd1, 5'd0, 5'd0), 1'b0);
        send(r_ins(F_GCD, 5'd1, 5'd2, 5'd3, 4'd0), of4(5'd3, 5'd1, 5'd2, 5'd0), 1'b0);
        vec_cnt++;
        if (m_regs[3] !== 16'h0006) begin
            $display("FAIL gcd_model: r3=%h required 0006", m_regs[3]);
            miscompares++;
        end
    endtask

    task automatic test_fail_cases();
        send(r_ins(F_GCD, 5'd1, 5'd4, 5'd3, 4'd0), of4(5'd1, 5'd2, 5'd3, 5'd4), 1'b0);
        send(r_ins(F_GCD, 5'd4, 5'd2, 5'd5, 4'd0), of4(5'd5, 5'd2, 5'd3, 5'd4), 1'b0);
        send(r_ins(F_ADD, 5'd0, 5'd0, 5'd0, 4'd0), of4(5'd1, 5'd2, 5'd3, 5'd4), 1'b0);
        send(r_ins(F_ADD, 5'd20, 5'd1, 5'd5, 4'd0), of4(5'd1, 5'd5, 5'd0, 5'd0), 1'b0);
        send(r_ins(7'b0111111, 5'd1, 5'd2, 5'd5, 4'd0), of4(5'd5, 5'd1, 5'd2, 5'd3), 1'b0);
        send({6'b100011, 26'h0}, of4(5'd0, 5'd1, 5'd2, 5'd3), 1'b0);
        send(r_ins(F_ADD, 5'd1, 5'd2, 5'd6, 4'd0), of4(5'd1, 5'd2, 5'd3, 5'd4), 1'b0);
        send(i_ins(5'd0, 5'd9, 16'h1234), of4(5'd1, 5'd2, 5'd3, 5'd4), 1'b0);
    endtask

    task automatic test_alu();
        send(i_ins(5'd0, 5'd5, 16'h0001), of4(5'd5, 5'd0, 5'd0, 5'd0), 1'b0);
        send(r_ins(F_SUB, 5'd0, 5'd5, 5'd4, 4'd0), of4(5'd4, 5'd5, 5'd0, 5'd1), 1'b0);
        vec_cnt++;
        if (m_regs[4] !== 16'hFFFF) begin
            $display("FAIL sub_wrap_model: r4=%h required ffff", m_regs[4]);
            miscompares++;
        end
        send(r_ins(F_ADD, 5'd1, 5'd2, 5'd3, 4'd0), of4(5'd3, 5'd1, 5'd2, 5'd31), 1'b0);
        send(r_ins(F_AND, 5'd4, 5'd1, 5'd3, 4'd0), of4(5'd3, 5'd4, 5'd1, 5'd2), 1'b0);
        send(r_ins(F_OR,  5'd1, 5'd2, 5'd3, 4'd0), of4(5'd3, 5'd3, 5'd3, 5'd3), 1'b0);
        send(r_ins(F_NOR, 5'd1, 5'd2, 5'd3, 4'd0), of4(5'd3, 5'd1, 5'd2, 5'd0), 1'b0);
        send(r_ins(F_SLT, 5'd1, 5'd4, 5'd3, 4'd0), of4(5'd3, 5'd0, 5'd0, 5'd0), 1'b0);
        send(r_ins(F_SLT, 5'd4, 5'd1, 5'd3, 4'd0), of4(5'd3, 5'd0, 5'd0, 5'd0), 1'b0);
        send(r_ins(F_SLL, 5'd0, 5'd1, 5'd3, 4'd4), of4(5'd3, 5'd1, 5'd0, 5'd0), 1'b0);
        send(r_ins(F_SRL, 5'd0, 5'd4, 5'd3, 4'd15), of4(5'd3, 5'd4, 5'd0, 5'd0), 1'b0);
        send(i_ins(5'd1, 5'd2, 16'hFFF0), of4(5'd2, 5'd1, 5'd0, 5'd0), 1'b0);
        send(r_ins(F_ADD, 5'd1, 5'd1, 5'd1, 4'd0), of4(5'd1, 5'd2, 5'd3, 5'd4), 1'b0);
        send(r_ins(F_GCD, 5'd2, 5'd2, 5'd3, 4'd0), of4(5'd3, 5'd2, 5'd0, 5'd0), 1'b0);
    endtask

    task automatic test_back_to_back();
        send(i_ins(5'd0, 5'd1, 16'h0054), of4(5'd1, 5'd0, 5'd0, 5'd0), 1'b0);
        send(i_ins(5'd0, 5'd2, 16'h0048), of4(5'd2, 5'd1, 5'd0, 5'd0), 1'b0);
        send(r_ins(F_GCD, 5'd1, 5'd2, 5'd3, 4'd0), of4(5'd3, 5'd1, 5'd2, 5'd0), 1'b1);
        send(r_ins(F_ADD, 5'd3, 5'd3, 5'd4, 4'd0), of4(5'd4, 5'd3, 5'd0, 5'd0), 1'b1);
    endtask

    task automatic test_random();
        logic [6:0]  fns [9];
        logic [4:0]  rs, rt, rd;
        logic [31:0] ins;
        int          pick;
        fns = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLL, F_SRL, F_GCD};
        for (int n = 0; n < 40; n++) begin
            rs = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5));
            rt = 5'($urandom_range(0, 5));
            rd = 5'($urandom_range(0, 5));
            pick = $urandom_range(0, 11);
            if (pick >= 9) ins = i_ins(rs, rt, 16'($urandom));
            else           ins = r_ins(fns[pick], rs, rt, rd, 4'($urandom));
            send(ins, of4(rd, rt, rs, 5'($urandom_range(0, 7))), n[0]);
        end
    endtask

    task automatic test_reset_mid_gcd();
        send(i_ins(5'd0, 5'd1, 16'hFFFE), of4(5'd1, 5'd0, 5'd0, 5'd0), 1'b0);
        send(i_ins(5'd0, 5'd2, 16'h0001), of4(5'd2, 5'd0, 5'd0, 5'd0), 1'b0);
        in_valid = 1'b1;
        instruction = r_ins(F_GCD, 5'd1, 5'd2, 5'd3, 4'd0);
        output_reg = of4(5'd3, 5'd1, 5'd2, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL mid_gcd_busy: ready=%b valid=%b required 0/0", in_ready, out_valid);
            miscompares++;
        end
        #2 rst_n = 1'b0;
        #1 check_idle_zero("reset_async");
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("reset_mid_release");
        send(r_ins(F_ADD, 5'd1, 5'd2, 5'd3, 4'd0), of4(5'd1, 5'd2, 5'd3, 5'd5), 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addi();
        test_gcd();
        test_fail_cases();
        test_alu();
        test_back_to_back();
        test_random();
        test_reset_mid_gcd();
        vec_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL leftover: %0d expectations not consumed, required 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end
endmodule
